// File: rtl/request_round_robin_arbiter.sv
// Round-robin arbiter that merges NUM_REQUEST request sources into one registered
// request slot feeding a downstream queue. Priority rotates starting after the last grant.
module request_round_robin_arbiter #(
   parameter int NUM_REQUEST                = 4,
   parameter int NUM_REQUEST_PTR_WIDTH      = $clog2(NUM_REQUEST),
   parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64
) (
   input  logic                                              clk_in,
   input  logic                                              reset_in,
   input  logic [NUM_REQUEST*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
   input  logic [NUM_REQUEST-1:0]                            request_valid_packed_in,
   output logic [NUM_REQUEST-1:0]                            issue_ack_packed_out,
   output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]             request_out,
   output logic                                              request_valid_out,
   input  logic                                              issue_ack_in
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                                  state;
   state_t                                  next_state;
   logic [NUM_REQUEST_PTR_WIDTH-1:0]        last_grant;
   logic [NUM_REQUEST_PTR_WIDTH-1:0]        next_last_grant;
   logic [NUM_REQUEST_PTR_WIDTH-1:0]        winner;
   logic [NUM_REQUEST_PTR_WIDTH-1:0]        idx;
   logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]   winner_payload;
   logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]   next_request;
   logic                                    found;
   logic                                    any_valid;
   logic                                    drain;
   logic                                    can_load;
   logic                                    load;

   assign request_valid_out = (state == FULL);
   assign any_valid         = |request_valid_packed_in;
   assign drain             = request_valid_out & issue_ack_in;
   assign can_load          = ~request_valid_out | drain;
   assign load              = can_load & any_valid & ~reset_in;

   // Pointer arithmetic wraps naturally because NUM_REQUEST is a power of two.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQUEST; k++) begin
         idx = last_grant + NUM_REQUEST_PTR_WIDTH'(k);
         if (!found && request_valid_packed_in[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      winner_payload = '0;
      for (int i = 0; i < NUM_REQUEST; i++) begin
         if (winner == NUM_REQUEST_PTR_WIDTH'(i)) begin
            winner_payload = request_packed_in[i*SINGLE_ENTRY_WIDTH_IN_BITS +: SINGLE_ENTRY_WIDTH_IN_BITS];
         end
      end
   end

   always_comb begin
      next_state           = state;
      next_request         = request_out;
      next_last_grant      = last_grant;
      issue_ack_packed_out = '0;
      if (load) begin
         issue_ack_packed_out[winner] = 1'b1;
         next_state                   = FULL;
         next_request                 = winner_payload;
         next_last_grant              = winner;
      end else if (drain) begin
         next_state   = EMPTY;
         next_request = '0;
      end
   end

   // last_grant resets to the top index so port 0 is searched first.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state       <= EMPTY;
         request_out <= '0;
         last_grant  <= '1;
      end else begin
         state       <= next_state;
         request_out <= next_request;
         last_grant  <= next_last_grant;
      end
   end

endmodule

// File: tb/tb_request_round_robin_arbiter.sv
// Directed bench for request_round_robin_arbiter: hand-checked scenarios plus a
// per-cycle behavioural model of the round-robin slot compared on every falling edge.
module tb_request_round_robin_arbiter;

   localparam int N = 4;
   localparam int W = 64;

   logic             clk_in = 1'b0;
   logic             reset_in;
   logic [N*W-1:0]   request_packed_in;
   logic [N-1:0]     request_valid_packed_in;
   logic [N-1:0]     issue_ack_packed_out;
   logic [W-1:0]     request_out;
   logic             request_valid_out;
   logic             issue_ack_in;

   logic [W-1:0]     pay [N];
   int               total = 0;
   int               bad = 0;
   logic             armed = 1'b0;

   logic             m_valid = 1'b0;
   logic [W-1:0]     m_data = '0;
   int               m_last = N - 1;

   request_round_robin_arbiter #(
      .NUM_REQUEST(N),
      .NUM_REQUEST_PTR_WIDTH($clog2(N)),
      .SINGLE_ENTRY_WIDTH_IN_BITS(W)
   ) dut (
      .clk_in(clk_in),
      .reset_in(reset_in),
      .request_packed_in(request_packed_in),
      .request_valid_packed_in(request_valid_packed_in),
      .issue_ack_packed_out(issue_ack_packed_out),
      .request_out(request_out),
      .request_valid_out(request_valid_out),
      .issue_ack_in(issue_ack_in)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=%h want=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkAll(input string name, input logic [N-1:0] exp_ack, input logic exp_valid, input logic [W-1:0] exp_data);
      checkOutput({name, "_ack"}, 64'(issue_ack_packed_out), 64'(exp_ack));
      checkOutput({name, "_valid"}, 64'(request_valid_out), 64'(exp_valid));
      checkOutput({name, "_data"}, request_out, exp_data);
   endtask

   // Inputs change just after a rising edge; checks happen on the following falling edge.
   task automatic applyStimulus(input logic rst, input logic [N-1:0] vld, input logic ack);
      @(posedge clk_in);
      #1;
      reset_in                = rst;
      request_valid_packed_in = vld;
      issue_ack_in            = ack;
      for (int i = 0; i < N; i++) request_packed_in[i*W +: W] = pay[i];
      @(negedge clk_in);
   endtask

   // Model: one slot, a rotating priority that starts just after the last winner.
   always @(negedge clk_in) begin : model_compare
      int           winner;
      int           cand;
      logic [N-1:0] exp_ack;
      if (armed) begin
         winner  = -1;
         exp_ack = '0;
         if (!reset_in && (!m_valid || issue_ack_in)) begin
            for (int k = 1; k <= N; k++) begin
               cand = (m_last + k) % N;
               if (winner < 0 && request_valid_packed_in[cand]) winner = cand;
            end
         end
         if (winner >= 0) exp_ack[winner] = 1'b1;
         checkOutput("model_ack", 64'(issue_ack_packed_out), 64'(exp_ack));
         checkOutput("model_valid", 64'(request_valid_out), 64'(m_valid));
         checkOutput("model_data", request_out, m_data);
         if (reset_in) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= N - 1;
         end else if (winner >= 0) begin
            m_valid <= 1'b1;
            m_data  <= request_packed_in[winner*W +: W];
            m_last  <= winner;
         end else if (m_valid && issue_ack_in) begin
            m_valid <= 1'b0;
            m_data  <= '0;
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) pay[i] = 64'h10 + 64'(i);
      reset_in                = 1'b1;
      request_valid_packed_in = '1;
      issue_ack_in            = 1'b1;
      for (int i = 0; i < N; i++) request_packed_in[i*W +: W] = pay[i];
      @(posedge clk_in);
      armed = 1'b1;

      // Reset held with every source requesting
      applyStimulus(1'b1, 4'b1111, 1'b1); checkAll("rst0", 4'b0000, 1'b0, 64'h0);
      applyStimulus(1'b1, 4'b1111, 1'b1); checkAll("rst1", 4'b0000, 1'b0, 64'h0);

      // Full rotation starting at port 0
      applyStimulus(1'b0, 4'b1111, 1'b1); checkAll("rot0", 4'b0001, 1'b0, 64'h0);
      applyStimulus(1'b0, 4'b1111, 1'b1); checkAll("rot1", 4'b0010, 1'b1, 64'h10);
      applyStimulus(1'b0, 4'b1111, 1'b1); checkAll("rot2", 4'b0100, 1'b1, 64'h11);
      applyStimulus(1'b0, 4'b1111, 1'b1); checkAll("rot3", 4'b1000, 1'b1, 64'h12);
      applyStimulus(1'b0, 4'b1111, 1'b1); checkAll("rot4", 4'b0001, 1'b1, 64'h13);
      applyStimulus(1'b0, 4'b1111, 1'b1); checkAll("rot5", 4'b0010, 1'b1, 64'h10);
      applyStimulus(1'b0, 4'b1111, 1'b1); checkAll("rot6", 4'b0100, 1'b1, 64'h11);
      applyStimulus(1'b0, 4'b1111, 1'b1); checkAll("rot7", 4'b1000, 1'b1, 64'h12);
      applyStimulus(1'b0, 4'b0000, 1'b1); checkAll("rot8", 4'b0000, 1'b1, 64'h13);
      applyStimulus(1'b0, 4'b0000, 1'b1); checkAll("rot9", 4'b0000, 1'b0, 64'h0);

      // Single source streaming on port 2
      pay[2] = 64'hA0;
      applyStimulus(1'b0, 4'b0100, 1'b1); checkAll("one0", 4'b0100, 1'b0, 64'h0);
      pay[2] = 64'hA1;
      applyStimulus(1'b0, 4'b0100, 1'b1); checkAll("one1", 4'b0100, 1'b1, 64'hA0);
      pay[2] = 64'hA2;
      applyStimulus(1'b0, 4'b0100, 1'b1); checkAll("one2", 4'b0100, 1'b1, 64'hA1);
      applyStimulus(1'b0, 4'b0000, 1'b1); checkAll("one3", 4'b0000, 1'b1, 64'hA2);
      applyStimulus(1'b0, 4'b0000, 1'b1); checkAll("one4", 4'b0000, 1'b0, 64'h0);

      // Backpressure while ports 1 and 3 wait
      pay[1] = 64'h55;
      pay[3] = 64'h33;
      applyStimulus(1'b0, 4'b0010, 1'b1); checkAll("bp0", 4'b0010, 1'b0, 64'h0);
      applyStimulus(1'b0, 4'b1010, 1'b0); checkAll("bp1", 4'b0000, 1'b1, 64'h55);
      applyStimulus(1'b0, 4'b1010, 1'b0); checkAll("bp2", 4'b0000, 1'b1, 64'h55);
      applyStimulus(1'b0, 4'b1010, 1'b0); checkAll("bp3", 4'b0000, 1'b1, 64'h55);
      applyStimulus(1'b0, 4'b1010, 1'b1); checkAll("bp4", 4'b1000, 1'b1, 64'h55);
      applyStimulus(1'b0, 4'b0000, 1'b0); checkAll("bp5", 4'b0000, 1'b1, 64'h33);

      // Wrap-around: last grant is port 3, so port 0 beats port 3
      applyStimulus(1'b0, 4'b1001, 1'b1); checkAll("wrap0", 4'b0001, 1'b1, 64'h33);
      applyStimulus(1'b0, 4'b0000, 1'b1); checkAll("wrap1", 4'b0000, 1'b1, 64'h10);

      // Reset while full and stalled
      pay[0] = 64'h77;
      applyStimulus(1'b0, 4'b0001, 1'b1); checkAll("mrst0", 4'b0001, 1'b0, 64'h0);
      applyStimulus(1'b0, 4'b1111, 1'b0); checkAll("mrst1", 4'b0000, 1'b1, 64'h77);
      applyStimulus(1'b1, 4'b1111, 1'b0); checkAll("mrst2", 4'b0000, 1'b1, 64'h77);
      applyStimulus(1'b0, 4'b1111, 1'b0); checkAll("mrst3", 4'b0001, 1'b0, 64'h0);
      applyStimulus(1'b0, 4'b0000, 1'b1); checkAll("mrst4", 4'b0000, 1'b1, 64'h77);

      @(posedge clk_in);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
